// File: rtl/computer_player.sv
`default_nettype none
// ============================================================================
//  Module   : computer_player
//  Purpose  : Automatic tic-tac-toe opponent. Waits THINK_DELAY cycles after
//             a player move, snapshots the board, scans the 8 lines for a
//             winning move and then for a blocking move, and falls back to
//             centre > corner > edge. The reply goes out with the board's own
//             timing: address stable one cycle before a 1-cycle move pulse.
//  Ports    : clk, rst (async, active-high)
//             player_move / player_address : player handshake in
//             led_0..led_8                 : cell states (00 empty, 01 player,
//                                            10 computer, 11 occupied)
//             win / tie                    : board end-of-game flags
//             computer_address / computer_move : reply to board
//             busy, game_over, move_overrun    : status
//  Revision : 1.0  initial release
// ============================================================================
module computer_player #(
  parameter int THINK_DELAY = 2,
  parameter bit START_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       player_move,
  input  logic [3:0] player_address,
  input  logic [1:0] led_0,
  input  logic [1:0] led_1,
  input  logic [1:0] led_2,
  input  logic [1:0] led_3,
  input  logic [1:0] led_4,
  input  logic [1:0] led_5,
  input  logic [1:0] led_6,
  input  logic [1:0] led_7,
  input  logic [1:0] led_8,
  input  logic       win,
  input  logic       tie,
  output logic [3:0] computer_address,
  output logic       computer_move,
  output logic       busy,
  output logic       game_over,
  output logic       move_overrun
);

  localparam logic [1:0] c_EMPTY      = 2'b00;
  localparam logic [1:0] c_PLAYER     = 2'b01;
  localparam logic [1:0] c_COMP       = 2'b10;
  localparam logic [3:0] c_NONE       = 4'd15;
  localparam logic [3:0] c_DELAY_LAST = 4'(THINK_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_SCAN_WIN = 3'd2,
    S_SCAN_BLK = 3'd3,
    S_DECIDE   = 3'd4,
    S_ADDR     = 3'd5,
    S_MOVE     = 3'd6,
    S_OVER     = 3'd7
  } state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_count;
  logic [3:0]  r_paddr;
  logic [2:0]  r_line;
  logic        r_opening;
  logic        r_first_done;
  logic        r_overrun;
  logic [17:0] r_snap;
  logic        r_win_found, r_blk_found;
  logic [3:0]  r_win_cell, r_blk_cell;
  logic [3:0]  r_computer_address;

  logic [17:0] w_live;
  logic [11:0] w_cells;
  logic [1:0]  w_va, w_vb, w_vc;
  logic [1:0]  w_n_comp, w_n_play, w_n_empty;
  logic [3:0]  w_gap;
  logic        w_win_hit, w_blk_hit;
  logic        w_open_go, w_move_legal;
  logic [3:0]  w_target;

  assign w_live = {led_8, led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0};

  // Out-of-range addresses read as occupied so they can never be legal or empty.
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
    case (idx)
      4'd0:    cell_of = b[1:0];
      4'd1:    cell_of = b[3:2];
      4'd2:    cell_of = b[5:4];
      4'd3:    cell_of = b[7:6];
      4'd4:    cell_of = b[9:8];
      4'd5:    cell_of = b[11:10];
      4'd6:    cell_of = b[13:12];
      4'd7:    cell_of = b[15:14];
      4'd8:    cell_of = b[17:16];
      default: cell_of = 2'b11;
    endcase
  endfunction

  // Scan order: rows, columns, diagonals.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // One line of the snapshot is evaluated per scan cycle.
  assign w_cells   = line_cells(r_line);
  assign w_va      = cell_of(r_snap, w_cells[11:8]);
  assign w_vb      = cell_of(r_snap, w_cells[7:4]);
  assign w_vc      = cell_of(r_snap, w_cells[3:0]);
  assign w_n_comp  = 2'(w_va == c_COMP)   + 2'(w_vb == c_COMP)   + 2'(w_vc == c_COMP);
  assign w_n_play  = 2'(w_va == c_PLAYER) + 2'(w_vb == c_PLAYER) + 2'(w_vc == c_PLAYER);
  assign w_n_empty = 2'(w_va == c_EMPTY)  + 2'(w_vb == c_EMPTY)  + 2'(w_vc == c_EMPTY);
  assign w_gap     = (w_va == c_EMPTY) ? w_cells[11:8] :
                     (w_vb == c_EMPTY) ? w_cells[7:4]  : w_cells[3:0];
  assign w_win_hit = (w_n_comp == 2'd2) && (w_n_empty == 2'd1);
  assign w_blk_hit = (w_n_play == 2'd2) && (w_n_empty == 2'd1);

  assign w_open_go = START_FIRST && !r_first_done;
  // The live LEDs are checked on the same cycle the snapshot is taken, so the
  // values tested are exactly the values latched.
  assign w_move_legal = r_opening || (cell_of(w_live, r_paddr) == c_PLAYER);

  always_comb begin
    w_target = c_NONE;
    if (r_win_found)                             w_target = r_win_cell;
    else if (r_blk_found)                        w_target = r_blk_cell;
    else if (cell_of(r_snap, 4'd4) == c_EMPTY)   w_target = 4'd4;
    else if (cell_of(r_snap, 4'd0) == c_EMPTY)   w_target = 4'd0;
    else if (cell_of(r_snap, 4'd2) == c_EMPTY)   w_target = 4'd2;
    else if (cell_of(r_snap, 4'd6) == c_EMPTY)   w_target = 4'd6;
    else if (cell_of(r_snap, 4'd8) == c_EMPTY)   w_target = 4'd8;
    else if (cell_of(r_snap, 4'd1) == c_EMPTY)   w_target = 4'd1;
    else if (cell_of(r_snap, 4'd3) == c_EMPTY)   w_target = 4'd3;
    else if (cell_of(r_snap, 4'd5) == c_EMPTY)   w_target = 4'd5;
    else if (cell_of(r_snap, 4'd7) == c_EMPTY)   w_target = 4'd7;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = 1'b0;
    computer_move = 1'b0;
    game_over     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (win || tie)                     w_next = S_OVER;
        else if (w_open_go || player_move)  w_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_count == 4'd0) w_next = w_move_legal ? S_SCAN_WIN : S_IDLE;
      end
      S_SCAN_WIN: begin
        busy = 1'b1;
        if (r_line == 3'd7) w_next = S_SCAN_BLK;
      end
      S_SCAN_BLK: begin
        busy = 1'b1;
        if (r_line == 3'd7) w_next = S_DECIDE;
      end
      S_DECIDE: begin
        busy = 1'b1;
        if (win || tie || (w_target == c_NONE)) w_next = S_OVER;
        else                                    w_next = S_ADDR;
      end
      S_ADDR: begin
        busy   = 1'b1;
        w_next = S_MOVE;
      end
      S_MOVE: begin
        busy          = 1'b1;
        computer_move = 1'b1;
        w_next        = S_IDLE;
      end
      S_OVER: game_over = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count            <= 4'd0;
      r_paddr            <= 4'd0;
      r_line             <= 3'd0;
      r_opening          <= 1'b0;
      r_first_done       <= 1'b0;
      r_overrun          <= 1'b0;
      r_snap             <= 18'd0;
      r_win_found        <= 1'b0;
      r_blk_found        <= 1'b0;
      r_win_cell         <= 4'd0;
      r_blk_cell         <= 4'd0;
      r_computer_address <= 4'd0;
    end else begin
      r_first_done <= 1'b1;
      if (player_move && busy) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_WAIT) begin
            r_count   <= c_DELAY_LAST;
            r_paddr   <= player_address;
            r_opening <= w_open_go;
          end
        end
        S_WAIT: begin
          r_count     <= r_count - 1'b1;
          r_line      <= 3'd0;
          r_win_found <= 1'b0;
          r_blk_found <= 1'b0;
          if (r_count == 4'd0) r_snap <= w_live;
        end
        S_SCAN_WIN: begin
          r_line <= r_line + 1'b1;
          if (w_win_hit && !r_win_found) begin
            r_win_found <= 1'b1;
            r_win_cell  <= w_gap;
          end
        end
        S_SCAN_BLK: begin
          r_line <= r_line + 1'b1;
          if (w_blk_hit && !r_blk_found) begin
            r_blk_found <= 1'b1;
            r_blk_cell  <= w_gap;
          end
        end
        S_DECIDE: begin
          if (w_next == S_ADDR) r_computer_address <= w_target;
        end
        default: ;
      endcase
    end
  end

  assign computer_address = r_computer_address;
  assign move_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_computer_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_computer_player
//  Purpose  : Self-checking bench for computer_player. Directed board
//             positions plus randomized boards checked against a move-choice
//             model written directly from the game rules, with reply timing
//             taken from the documented latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_computer_player;

  localparam int TD = 2;
  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic       clk = 1'b0;
  logic       rst;
  logic       player_move;
  logic [3:0] player_address;
  logic [1:0] led [9];
  logic       win, tie;
  logic [3:0] computer_address;
  logic       computer_move, busy, game_over, move_overrun;

  logic [3:0] sf_address;
  logic       sf_move, sf_busy, sf_over, sf_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  computer_player #(.THINK_DELAY(TD), .START_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .player_move(player_move), .player_address(player_address),
    .led_0(led[0]), .led_1(led[1]), .led_2(led[2]), .led_3(led[3]), .led_4(led[4]),
    .led_5(led[5]), .led_6(led[6]), .led_7(led[7]), .led_8(led[8]),
    .win(win), .tie(tie), .computer_address(computer_address),
    .computer_move(computer_move), .busy(busy), .game_over(game_over),
    .move_overrun(move_overrun)
  );

  computer_player #(.THINK_DELAY(TD), .START_FIRST(1'b1)) dut_sf (
    .clk(clk), .rst(rst), .player_move(1'b0), .player_address(4'd0),
    .led_0(2'b00), .led_1(2'b00), .led_2(2'b00), .led_3(2'b00), .led_4(2'b00),
    .led_5(2'b00), .led_6(2'b00), .led_7(2'b00), .led_8(2'b00),
    .win(1'b0), .tie(1'b0), .computer_address(sf_address),
    .computer_move(sf_move), .busy(sf_busy), .game_over(sf_over),
    .move_overrun(sf_overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rule-level reference: win > block > centre > corner > edge; -1 = no move.
  function automatic int model_pick(input int b[9]);
    int corners[4] = '{0, 2, 6, 8};
    int edges[4]   = '{1, 3, 5, 7};
    for (int who = 2; who >= 1; who--) begin
      for (int l = 0; l < 8; l++) begin
        int n_own = 0;
        int n_emp = 0;
        int gap = -1;
        for (int k = 0; k < 3; k++) begin
          if (b[LINES[l][k]] == who) n_own++;
          else if (b[LINES[l][k]] == 0) begin
            n_emp++;
            gap = LINES[l][k];
          end
        end
        if (n_own == 2 && n_emp == 1) return gap;
      end
    end
    if (b[4] == 0) return 4;
    for (int i = 0; i < 4; i++) if (b[corners[i]] == 0) return corners[i];
    for (int i = 0; i < 4; i++) if (b[edges[i]] == 0) return edges[i];
    return -1;
  endfunction

  task automatic set_board(input int b[9]);
    for (int i = 0; i < 9; i++) led[i] = 2'(b[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // kind: 0 illegal move, 1 normal reply, 2 no empty cell (game over), 3 already over
  task automatic run_move(input string tag, input int b[9], input int addr,
                          input int dup_at, input int kind, input int exp_addr);
    int pulses = 0;
    int pcyc = -1;
    int apulse = -1;
    int a_early = -1;
    int busy_n = 0;
    int busy_last = 0;
    set_board(b);
    @(posedge clk); #1 player_address = 4'(addr); player_move = 1'b1;
    @(posedge clk); #1 player_move = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == dup_at + 1) player_move = 1'b0;
      if (busy) begin
        busy_n++;
        busy_last = c;
      end
      if (computer_move) begin
        pulses++;
        if (pcyc < 0) begin
          pcyc = c;
          apulse = int'(computer_address);
        end
      end
      if (c == TD + 18) a_early = int'(computer_address);
      if (c == dup_at) player_move = 1'b1;
    end
    case (kind)
      1: begin
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_pulse_cycle"}, pcyc, TD + 19);
        check({tag, "_addr_at_pulse"}, apulse, exp_addr);
        check({tag, "_addr_before_pulse"}, a_early, exp_addr);
        check({tag, "_busy_cycles"}, busy_n, TD + 19);
        check({tag, "_busy_last"}, busy_last, TD + 19);
      end
      2: begin
        check({tag, "_pulses"}, pulses, 0);
        check({tag, "_busy_cycles"}, busy_n, TD + 17);
        check({tag, "_game_over"}, int'(game_over), 1);
      end
      3: begin
        check({tag, "_pulses"}, pulses, 0);
        check({tag, "_busy_cycles"}, busy_n, 0);
        check({tag, "_game_over"}, int'(game_over), 1);
      end
      default: begin
        check({tag, "_pulses"}, pulses, 0);
        check({tag, "_busy_cycles"}, busy_n, TD);
        check({tag, "_busy_last"}, busy_last, TD);
      end
    endcase
  endtask

  initial begin
    int b[9];
    int sf_pulses, sf_cyc, sf_addr, main_pulses, pulses, busy_n;
    rst = 1'b0; player_move = 1'b0; player_address = 4'd0; win = 1'b0; tie = 1'b0;
    for (int i = 0; i < 9; i++) led[i] = 2'b00;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_addr", int'(computer_address), 0);
    check("rst_move", int'(computer_move), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_overrun", int'(move_overrun), 0);
    check("rst_sf_addr", int'(sf_address), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Opening move of the START_FIRST instance; the other one must stay idle
    sf_pulses = 0; sf_cyc = -1; sf_addr = -1; main_pulses = 0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (sf_move) begin
        sf_pulses++;
        if (sf_cyc < 0) begin
          sf_cyc = c;
          sf_addr = int'(sf_address);
        end
      end
      if (computer_move || busy) main_pulses++;
    end
    check("sf_pulses", sf_pulses, 1);
    check("sf_cycle", sf_cyc, TD + 19);
    check("sf_addr", sf_addr, 4);
    check("idle_quiet", main_pulses, 0);

    // Directed positions
    b = '{0,0,0, 0,1,0, 0,0,0};  run_move("centre_reply", b, 4, 0, 1, 0);
    b = '{1,1,0, 0,2,0, 0,0,0};  run_move("block", b, 1, 0, 1, 2);
    b = '{1,1,0, 2,2,0, 0,0,0};  run_move("win_over_block", b, 1, 0, 1, 5);
    b = '{1,3,3, 3,3,3, 3,3,0};  run_move("code11_occupied", b, 0, 0, 1, 8);
    b = '{0,0,0, 0,2,0, 0,0,0};  run_move("illegal_comp_cell", b, 4, 0, 0, 0);
    b = '{0,0,0, 0,0,0, 0,0,0};  run_move("illegal_addr9", b, 9, 0, 0, 0);
    b = '{0,1,0, 0,0,0, 0,0,0};  run_move("illegal_empty_cell", b, 0, 0, 0, 0);

    // Randomized boards against the rule model
    for (int i = 0; i < 24; i++) begin
      int addr;
      int r;
      bit has_empty;
      for (int k = 0; k < 9; k++) begin
        r = int'($urandom_range(0, 9));
        b[k] = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) addr = int'($urandom_range(9, 15));
        else begin
          addr = int'($urandom_range(0, 8));
          r = int'($urandom_range(0, 2));
          b[addr] = (r == 0) ? 0 : (r == 1) ? 2 : 3;
        end
        run_move($sformatf("rnd%0d_illegal", i), b, addr, 0, 0, 0);
      end else begin
        addr = int'($urandom_range(0, 8));
        b[addr] = 1;
        has_empty = 1'b0;
        for (int k = 0; k < 9; k++) if (b[k] == 0) has_empty = 1'b1;
        if (!has_empty) b[(addr + 1 + int'($urandom_range(0, 7))) % 9] = 0;
        run_move($sformatf("rnd%0d", i), b, addr, 0, 1, model_pick(b));
      end
    end

    // Second player_move while busy: one reply only, overrun flagged
    b = '{0,0,0, 0,1,0, 0,0,0};
    run_move("overrun", b, 4, 5, 1, 0);
    check("overrun_flag", int'(move_overrun), 1);
    do_reset();
    check("overrun_cleared", int'(move_overrun), 0);

    // Reset in the middle of a reply
    set_board(b);
    @(posedge clk); #1 player_address = 4'd4; player_move = 1'b1;
    @(posedge clk); #1 player_move = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_move", int'(computer_move), 0);
    check("midrst_addr", int'(computer_address), 0);
    check("midrst_over", int'(game_over), 0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0; busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (computer_move) pulses++;
      if (busy) busy_n++;
    end
    check("midrst_no_pulse", pulses, 0);
    check("midrst_no_busy", busy_n, 0);

    // Player fills the last empty cell: no reply possible
    b = '{1,2,1, 1,2,2, 2,1,1};
    run_move("full_board", b, 0, 0, 2, 0);
    do_reset();
    check("full_cleared", int'(game_over), 0);

    // win reported while idle
    @(posedge clk); #1 win = 1'b1;
    @(posedge clk); #1 win = 1'b0;
    @(negedge clk);
    check("win_game_over", int'(game_over), 1);
    b = '{0,0,0, 0,1,0, 0,0,0};
    run_move("after_win", b, 4, 0, 3, 0);
    do_reset();
    check("win_cleared", int'(game_over), 0);

    // tie reported while idle
    @(posedge clk); #1 tie = 1'b1;
    @(posedge clk); #1 tie = 1'b0;
    @(negedge clk);
    check("tie_game_over", int'(game_over), 1);
    do_reset();
    check("tie_cleared", int'(game_over), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
